ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sequences and shares the single-port 16x8 synchronous RAM (SyncRAM: clk, we, addr, din, dout) between two requesters.
- After reset it optionally clears every RAM word to zero. It then serves requests one per cycle with round-robin arbitration, and returns read data with a one-cycle response strobe.
- Sits between client logic and the SyncRAM instance; it is the only driver of the RAM's we/addr/din.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- INIT_CLEAR, 1, 1 = zero-fill the RAM after reset; 0 = skip the fill.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- rsp0_valid  out  1  port 0 read data valid, one-cycle pulse.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- ram_we  out  1  to SyncRAM we.
- ram_addr  out  ADDR_W  to SyncRAM addr.
- ram_din  out  DATA_W  to SyncRAM din.
- ram_dout  in  DATA_W  from SyncRAM dout; registered read, valid one cycle after the address edge.
- init_done  out  1  high once the RAM is usable.

Behaviour:
- Reset (rst_n=0, asynchronous): state goes to INIT, or to RUN when INIT_CLEAR=0. Clear counter = 0, rr pointer = port 0, rsp*_valid = 0, rsp*_rdata = 0, init_done = 0. While in reset, req*_ready, ram_we, ram_addr and ram_din are all 0.
- INIT state:
  - Each cycle: ram_we=1, ram_addr=counter, ram_din=0; counter increments.
  - Both req*_ready held 0.
  - After the write to address 2**ADDR_W-1, go to RUN.
  - init_done is registered: it rises on the first RUN cycle, 16 cycles after reset release at defaults.
- INIT_CLEAR=0: init_done = 1 from the first clock edge after reset release.
- RUN state, arbitration (combinational, same cycle):
  - Only one valid → grant it.
  - Both valid → grant the port named by the rr pointer.
  - rr pointer moves to the other port after every grant.
- RUN state, ram signals:
  - Granted port: req_ready=1; ram_we, ram_addr, ram_din follow that port's we/addr/wdata.
  - No grant: ram_we=0, ram_addr=0, ram_din=0.
- Handshake:
  - A request transfers when valid && ready.
  - The requester holds valid and its fields stable until ready.
  - ready never depends on ready.
- Read response:
  - A read accepted at edge N gives rsp_valid=1 for exactly the cycle after edge N+1... more precisely, the cycle following the accept, with rsp_rdata = ram_dout.
  - A one-bit tag register records which port's read is in flight.
  - Back-to-back reads are supported, one response per cycle.
  - Writes produce no response.
- rsp_rdata holds its last value when rsp_valid=0.
- Ordering: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later, from either port.
- Reset mid-INIT or mid-RUN: an in-flight response is dropped (rsp_valid goes 0 immediately), and the clear restarts from address 0.
- Addresses wrap naturally at ADDR_W; no out-of-range case exists.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum {INIT, RUN};
  - port index constants P0=0, P1=1;
  - default ADDR_W/DATA_W values.
- One sub-module: rr_arb2, the two-requester round-robin picker (inputs req[1:0] and pointer; outputs one-hot grant and next pointer).

Test Plan:
- Reset release, INIT_CLEAR=1, no requests → ram_we=1 for 16 consecutive cycles with addr 0..15 and din 00; init_done rises on cycle 17; a later read of addr 2 returns 00.
- After init: port 0 writes A5 to addr 4, then reads addr 4 → rsp0_valid pulses once, one cycle after the accept, with rsp0_rdata=A5; rsp1_valid stays 0.
- Both ports valid for 4 cycles: port 0 writes 3C to addr 7 repeatedly, port 1 reads addr 7 repeatedly → grants alternate P0, P1, P0, P1; each port-1 read returns 3C.
- Port 1 alone issues 3 back-to-back reads of addr 4, 7, 2 → ready=1 every cycle; rsp1 pulses on 3 consecutive cycles returning A5, 3C, 00.
- Requests during INIT → ready stays 0 until the init_done cycle; the held request is accepted in the first RUN cycle.
- rst_n asserted the cycle after a read accept → rsp_valid never pulses; INIT restarts from addr 0; address 4 afterwards reads 00.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Requester, response and SyncRAM signals of the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              init_done;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_dout,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_we, ram_addr, ram_din, init_done
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_dout,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_we, ram_addr, ram_din, init_done
    );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_ptr == P0) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase

        // Pointer always lands on the port that was not just served.
        o_next_ptr = i_ptr;
        if (o_grant[0]) begin
            o_next_ptr = P1;
        end else if (o_grant[1]) begin
            o_next_ptr = P0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Clears a 16x8 SyncRAM after reset, then shares it between two
//               requesters with round-robin arbitration and read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ptr;
    logic              r_init_done;
    logic              r_pend;
    logic              r_tag;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic [DATA_W-1:0] r_rsp1_rdata;

    logic [1:0]        w_grant;
    logic              w_next_ptr;
    logic              w_run;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_din;
    logic              w_read_acc;

    rr_arb2 u_rr_arb2 (
        .i_req      ({bus.req1_valid, bus.req0_valid}),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    // Reset gates the combinational outputs so nothing reaches the RAM while held.
    assign w_run = rst_n && (r_state == RUN);

    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        w_ram_din  = '0;
        if (rst_n && (r_state == INIT)) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_cnt;
        end else if (w_run && w_grant[1]) begin
            w_ram_we   = bus.req1_we;
            w_ram_addr = bus.req1_addr;
            w_ram_din  = bus.req1_wdata;
        end else if (w_run && w_grant[0]) begin
            w_ram_we   = bus.req0_we;
            w_ram_addr = bus.req0_addr;
            w_ram_din  = bus.req0_wdata;
        end
    end

    assign w_read_acc = w_run && (|w_grant) && !w_ram_we;

    assign bus.req0_ready = w_run && w_grant[0];
    assign bus.req1_ready = w_run && w_grant[1];
    assign bus.ram_we     = w_ram_we;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_din    = w_ram_din;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp0_rdata = r_rsp0_rdata;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp1_rdata = r_rsp1_rdata;
    assign bus.init_done  = r_init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= (INIT_CLEAR != 0) ? INIT : RUN;
            r_cnt        <= '0;
            r_ptr        <= P0;
            r_init_done  <= 1'b0;
            r_pend       <= 1'b0;
            r_tag        <= P0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_init_done <= 1'b1;
                    if (|w_grant) begin
                        r_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= INIT;
            endcase

            // Registered RAM read: dout is valid the cycle after the accept edge.
            r_pend <= w_read_acc;
            if (w_read_acc) begin
                r_tag <= w_grant[1] ? P1 : P0;
            end
            r_rsp0_valid <= r_pend && (r_tag == P0);
            r_rsp1_valid <= r_pend && (r_tag == P1);
            if (r_pend && (r_tag == P0)) begin
                r_rsp0_rdata <= bus.ram_dout;
            end
            if (r_pend && (r_tag == P1)) begin
                r_rsp1_rdata <= bus.ram_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a SyncRAM model and
//               a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int c_aw = 4;
    localparam int c_dw = 8;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(c_aw), .DATA_W(c_dw)) bus ();

    ram_arbiter #(.ADDR_W(c_aw), .DATA_W(c_dw), .INIT_CLEAR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SyncRAM model, preloaded with non-zero junk so the clear is observable.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        bus.ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: port %0d pulsed with no pending read at %0t", p, $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("rsp_port", p, e.port);
                        check("rsp_data", (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input logic p);
        return p ? bus.req1_ready : bus.req0_ready;
    endfunction

    // Issue one request and hold it until accepted; called #1 after a posedge.
    task automatic issue(input logic p, input logic we, input logic [3:0] a,
                         input logic [7:0] d, input logic exp_rsp, input logic [7:0] exp_d);
        int waited;
        if (p) begin
            bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end
        waited = 0;
        @(negedge clk);
        while (!rdy(p) && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!rdy(p)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: port %0d never ready, got 0 required 1", p);
        end else if (!we && exp_rsp) begin
            q.push_back('{port: p, data: exp_d});
        end
        tick();
        if (p) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            waited++;
            tick();
        end
        check("rsp_missing", q.size(), 0);
    endtask

    task automatic wait_init();
        int waited;
        waited = 0;
        while (!bus.init_done && waited < 40) begin
            waited++;
            tick();
        end
        check("init_done_wait", bus.init_done, 1);
    endtask

    initial begin
        logic [3:0] b2b_addr [3];
        logic [7:0] b2b_data [3];
        int         cnt;
        b2b_addr = '{4'h4, 4'h7, 4'h2};
        b2b_data = '{8'hA5, 8'h3C, 8'h00};

        // Reset with a write held on port 0: nothing may leak through.
        idle();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 4'h9; bus.req0_wdata = 8'h11;
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_din", bus.ram_din, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp0_rdata", bus.rsp0_rdata, 0);
        idle();
        tick();
        rst_n = 1'b1;

        // Clear sequence: 16 writes of 00 to addresses 0..15.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("init_we", bus.ram_we, 1);
            check("init_addr", bus.ram_addr, i);
            check("init_din", bus.ram_din, 0);
            check("init_done_low", bus.init_done, 0);
        end
        @(negedge clk);
        check("init_done_rise", bus.init_done, 1);
        check("run_idle_we", bus.ram_we, 0);
        tick();

        // Single-port write/read, then a port-1 read of a cleared word.
        issue(1'b0, 1'b1, 4'h4, 8'hA5, 1'b0, 8'h00);
        issue(1'b0, 1'b0, 4'h4, 8'h00, 1'b1, 8'hA5);
        issue(1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 8'h00);
        drain();

        // Contention: last grant went to P1, so P0 wins first and grants alternate.
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 4'h7; bus.req0_wdata = 8'h3C;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 4'h7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arb_gnt0", bus.req0_ready, logic'(k % 2 == 0));
            check("arb_gnt1", bus.req1_ready, logic'(k % 2 == 1));
            if (k % 2 == 1) q.push_back('{port: 1'b1, data: 8'h3C});
            tick();
        end
        idle();
        drain();

        // Back-to-back port-1 reads.
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.req1_addr = b2b_addr[k];
            @(negedge clk);
            check("b2b_ready", bus.req1_ready, 1);
            q.push_back('{port: 1'b1, data: b2b_data[k]});
            tick();
        end
        idle();
        drain();
        @(negedge clk);
        check("rdata_hold0", bus.rsp0_rdata, 8'hA5);
        tick();

        // Request held across reset and INIT: accepted on the first RUN cycle.
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 4'h4;
        @(negedge clk);
        check("rst2_ready0", bus.req0_ready, 0);
        check("rst2_init_done", bus.init_done, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!bus.init_done && cnt < 40) begin
            check("init_hold_ready", bus.req0_ready, 0);
            cnt++;
            @(negedge clk);
        end
        check("init_done_cycles", cnt, 16);
        check("init_first_run_ready", bus.req0_ready, 1);
        q.push_back('{port: 1'b0, data: 8'h00});
        tick();
        idle();
        drain();

        // Reset right after a read accept drops the response and restarts the clear.
        issue(1'b0, 1'b1, 4'h4, 8'h5A, 1'b0, 8'h00);
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 4'h4;
        @(negedge clk);
        check("drop_ready1", bus.req1_ready, 1);
        tick();
        rst_n = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drop_rsp1_valid", bus.rsp1_valid, 0);
            check("drop_rsp0_valid", bus.rsp0_valid, 0);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_we", bus.ram_we, 1);
        check("restart_addr", bus.ram_addr, 0);
        check("restart_rsp1_valid", bus.rsp1_valid, 0);
        tick();
        wait_init();
        issue(1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
